ped_crossing_ctrl: RTL and testbench
====================================

// Module: ped_crossing_ctrl
// PURPOSE
//  Pedestrian crossing controller downstream of the TRAFFIC light sequencer.
//  Consumes the vehicle light code {Red,Yellow,Green}, latches pedestrian button
//  requests, grants a WALK phase only while vehicles see solid red, then a
//  flashing DON'T-WALK clearance phase. Invalid light codes force a sticky safe state.
// PARAMETERS
//  WALK_CYCLES   8   clocks of solid WALK per grant (>=1)
//  FLASH_CYCLES  4   clocks of flashing clearance after WALK (>=1)
//  CNT_W         4   countdown width; must hold WALK_CYCLES+FLASH_CYCLES-1
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  light        in   3      vehicle lights {Red,Yellow,Green}, from TRAFFIC
//  ped_btn      in   1      pedestrian button level; rising edge = request
//  walk         out  1      WALK lamp
//  dont_walk    out  1      DON'T-WALK lamp (toggles in clearance)
//  flash        out  1      high during clearance phase
//  req_pending  out  1      request latched, not yet served
//  countdown    out  CNT_W  clocks remaining in WALK+clearance; 0 otherwise
//  fault        out  1      sticky invalid-light-code flag
// BEHAVIOUR
//  - All outputs registered. Reset values: walk=0 dont_walk=1 flash=0
//    req_pending=0 countdown=0 fault=0; state=IDLE, armed=1, btn_q=0.
//  - Valid light codes: 100, 010, 001. Any other value sampled at an edge ->
//    FAULT from next cycle: walk=0 dont_walk=1 flash=0 countdown=0 fault=1.
//    FAULT exits only via rst; buttons ignored. Fault check has priority.
//  - Button edge: btn_edge = ped_btn & ~btn_q. btn_edge sets req_pending
//    in IDLE and CLEAR; ignored in WALK. req_pending cleared on entry to WALK
//    (clear wins over a simultaneous btn_edge).
//  - armed: cleared on entry to WALK; set whenever light != 100 is sampled.
//  - States:
//    IDLE : walk=0 dont_walk=1. If req_pending & armed & light==100 -> WALK.
//           Button sampled high at edge N -> req_pending=1 after N -> walk=1
//           after edge N+1 (if red already showing and armed).
//    WALK : walk=1 dont_walk=0 flash=0; countdown loaded WALK_CYCLES+
//           FLASH_CYCLES-1 on entry, decrements each clock. After WALK_CYCLES
//           clocks -> CLEAR.
//    CLEAR: walk=0 flash=1; dont_walk = 1,0,1,0,... starting 1 on first CLEAR
//           clock; countdown keeps decrementing, reaches 0 on last CLEAR
//           clock. After FLASH_CYCLES clocks -> IDLE (countdown 0, dont_walk=1).
//  - Abort: light leaves 100 (valid code) while in WALK or CLEAR -> IDLE on
//    next edge, walk=0 dont_walk=1 flash=0 countdown=0; req_pending kept.
//  - No second WALK within one red phase: armed must be re-set by a non-red
//    code before a pending request is served.
//  - rst mid-operation: all reset values on next edge, pending request dropped.
//  - countdown never wraps; it is 0 in IDLE/FAULT.
// TESTING
//  1 rst=1 two clocks, light=001 -> walk=0 dont_walk=1 flash=0 countdown=0
//    fault=0 req_pending=0.
//  2 light=001, ped_btn pulse 1 clk -> req_pending=1; light=100 -> walk=1 next
//    edge, countdown=11 down to 4 over 8 clks, then flash=1 4 clks with
//    dont_walk 1,0,1,0, countdown 3..0, then IDLE, req_pending=0.
//  3 In WALK 3rd clock set light=001 -> next edge walk=0 dont_walk=1 flash=0
//    countdown=0; no re-grant until light returns to 100 with a request.
//  4 Press during CLEAR, light held 100 -> no WALK after IDLE; light 010 then
//    100 -> WALK granted.
//  5 light=110 one clock -> fault=1 dont_walk=1 walk=0, held through valid
//    lights and button presses; rst -> fault=0.
//  6 rst asserted mid-WALK with req pending -> reset values next edge.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK/clearance sequencer driven by the vehicle light code,
// with latched button requests, one grant per red phase and a sticky fault on bad codes.
module ped_crossing_ctrl #(
   parameter int WALK_CYCLES  = 8,
   parameter int FLASH_CYCLES = 4,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light,
   input  logic             ped_btn,
   output logic             walk,
   output logic             dont_walk,
   output logic             flash,
   output logic             req_pending,
   output logic [CNT_W-1:0] countdown,
   output logic             fault
);
   typedef enum logic [1:0] {IDLE, WALK, CLEAR, FAULT} state_t;
   localparam logic [CNT_W-1:0] LOAD    = CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLASH_N = CNT_W'(FLASH_CYCLES);
   state_t state;
   logic   armed;
   logic   btn_q;
   logic   valid;
   logic   red;
   logic   btn_edge;
   assign red      = light == 3'b100;
   assign valid    = red | (light == 3'b010) | (light == 3'b001);
   assign btn_edge = ped_btn & ~btn_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         armed       <= 1'b1;
         btn_q       <= 1'b0;
         walk        <= 1'b0;
         dont_walk   <= 1'b1;
         flash       <= 1'b0;
         req_pending <= 1'b0;
         countdown   <= '0;
         fault       <= 1'b0;
      end else begin
         btn_q <= ped_btn;
         if (!red) armed <= 1'b1;
         if (state != FAULT && !valid) begin
            state     <= FAULT;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            flash     <= 1'b0;
            countdown <= '0;
            fault     <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (req_pending && armed && red) begin
                     state       <= WALK;
                     walk        <= 1'b1;
                     dont_walk   <= 1'b0;
                     countdown   <= LOAD;
                     req_pending <= 1'b0;
                     armed       <= 1'b0;
                  end else if (btn_edge) req_pending <= 1'b1;
               end
               WALK: begin
                  if (!red) begin
                     state     <= IDLE;
                     walk      <= 1'b0;
                     dont_walk <= 1'b1;
                     countdown <= '0;
                  end else begin
                     countdown <= countdown - 1'b1;
                     // countdown equals FLASH_CYCLES on the last WALK clock
                     if (countdown == FLASH_N) begin
                        state     <= CLEAR;
                        walk      <= 1'b0;
                        flash     <= 1'b1;
                        dont_walk <= 1'b1;
                     end
                  end
               end
               CLEAR: begin
                  if (btn_edge) req_pending <= 1'b1;
                  if (!red || countdown == '0) begin
                     state     <= IDLE;
                     dont_walk <= 1'b1;
                     flash     <= 1'b0;
                     countdown <= '0;
                  end else begin
                     countdown <= countdown - 1'b1;
                     dont_walk <= ~dont_walk;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed scenarios plus random traffic, checked every cycle against
// a model that tracks only "clocks since grant" and derives all lamp outputs from it.
module tb_ped_crossing_ctrl;
   localparam int W = 8, F = 4, CW = 4, C = W + F;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    light = 3'b001;
   logic          ped_btn = 1'b0;
   logic          walk, dont_walk, flash, req_pending, fault;
   logic [CW-1:0] countdown;
   int            npass = 0;
   int            ntot = 0;
   bit            mf, mreq, marm, mpb;
   int            mt;
   ped_crossing_ctrl #(.WALK_CYCLES(W), .FLASH_CYCLES(F), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .light(light), .ped_btn(ped_btn), .walk(walk),
      .dont_walk(dont_walk), .flash(flash), .req_pending(req_pending),
      .countdown(countdown), .fault(fault)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask
   // model: mt = clocks since grant (-1 when no WALK/CLEAR in progress)
   task automatic model_edge(input logic r, input logic [2:0] l, input logic b);
      bit edge_b, red, valid, inclear;
      if (r) begin
         mf = 0; mreq = 0; marm = 1; mpb = 0; mt = -1;
         return;
      end
      edge_b = b && !mpb;
      mpb = b;
      red = l == 3'b100;
      valid = red || l == 3'b010 || l == 3'b001;
      if (mf) return;
      if (!valid) begin
         mf = 1; mt = -1;
         return;
      end
      if (mt < 0) begin
         if (mreq && marm && red) begin
            mt = 0; mreq = 0; marm = 0;
         end else if (edge_b) mreq = 1;
      end else begin
         inclear = mt >= W;
         if (inclear && edge_b) mreq = 1;
         if (!red) mt = -1;
         else begin
            mt++;
            if (mt == C) mt = -1;
         end
      end
      if (!red) marm = 1;
   endtask
   function automatic int model_out();
      bit w, dw, fl;
      int cd;
      if (mf || mt < 0) begin
         w = 0; dw = 1; fl = 0; cd = 0;
      end else if (mt < W) begin
         w = 1; dw = 0; fl = 0; cd = C - 1 - mt;
      end else begin
         w = 0; fl = 1; dw = ((mt - W) % 2) == 0; cd = C - 1 - mt;
      end
      return {w, dw, fl, mreq, mf, cd[CW-1:0]};
   endfunction
   task automatic step(input logic r, input logic [2:0] l, input logic b);
      rst = r; light = l; ped_btn = b;
      @(posedge clk);
      model_edge(r, l, b);
      @(negedge clk);
      chk("outputs{walk,dw,flash,req,fault,cd}",
          int'({walk, dont_walk, flash, req_pending, fault, countdown}), model_out());
   endtask
   initial begin
      logic [2:0] bad [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      logic [2:0] cur;
      int rr;
      mf = 0; mreq = 0; marm = 1; mpb = 0; mt = -1;
      step(1, 3'b001, 0);
      step(1, 3'b001, 0);
      chk("rst_walk", walk, 0); chk("rst_dw", dont_walk, 1); chk("rst_flash", flash, 0);
      chk("rst_cd", countdown, 0); chk("rst_fault", fault, 0); chk("rst_req", req_pending, 0);
      step(0, 3'b001, 1);
      chk("req_latched", req_pending, 1);
      step(0, 3'b001, 0);
      step(0, 3'b100, 0);
      chk("grant_walk", walk, 1); chk("grant_cd", countdown, 11); chk("grant_req_clr", req_pending, 0);
      repeat (7) step(0, 3'b100, 0);
      chk("walk_last_cd", countdown, 4); chk("walk_last_walk", walk, 1);
      step(0, 3'b100, 0);
      chk("clr1_flash", flash, 1); chk("clr1_dw", dont_walk, 1); chk("clr1_cd", countdown, 3);
      step(0, 3'b100, 0);
      chk("clr2_dw", dont_walk, 0); chk("clr2_cd", countdown, 2);
      repeat (2) step(0, 3'b100, 0);
      chk("clr4_cd", countdown, 0); chk("clr4_dw", dont_walk, 0);
      step(0, 3'b100, 0);
      chk("idle_flash", flash, 0); chk("idle_dw", dont_walk, 1); chk("idle_walk", walk, 0);
      step(0, 3'b010, 1);
      step(0, 3'b010, 0);
      step(0, 3'b100, 0);
      step(0, 3'b100, 0);
      step(0, 3'b100, 0);
      step(0, 3'b001, 0);
      chk("abort_walk", walk, 0); chk("abort_dw", dont_walk, 1); chk("abort_cd", countdown, 0);
      repeat (3) step(0, 3'b100, 0);
      chk("no_regrant", walk, 0);
      step(0, 3'b100, 1);
      step(0, 3'b100, 0);
      chk("grant2_walk", walk, 1);
      repeat (8) step(0, 3'b100, 0);
      step(0, 3'b100, 1);
      chk("clear_press_req", req_pending, 1);
      repeat (6) step(0, 3'b100, 0);
      chk("unarmed_no_walk", walk, 0); chk("unarmed_req_kept", req_pending, 1);
      step(0, 3'b010, 0);
      step(0, 3'b100, 0);
      chk("rearmed_walk", walk, 1);
      step(0, 3'b110, 0);
      chk("fault_set", fault, 1); chk("fault_walk", walk, 0); chk("fault_dw", dont_walk, 1);
      step(0, 3'b100, 1); step(0, 3'b010, 0); step(0, 3'b001, 1); step(0, 3'b100, 0);
      chk("fault_sticky", fault, 1); chk("fault_no_walk", walk, 0);
      step(1, 3'b001, 0);
      chk("fault_rst", fault, 0);
      step(0, 3'b001, 1);
      step(0, 3'b100, 0);
      repeat (8) step(0, 3'b100, 0);
      step(0, 3'b100, 1);
      chk("mid_req", req_pending, 1); chk("mid_flash", flash, 1);
      step(1, 3'b100, 0);
      chk("mid_rst_req", req_pending, 0); chk("mid_rst_flash", flash, 0);
      chk("mid_rst_cd", countdown, 0); chk("mid_rst_dw", dont_walk, 1);
      cur = 3'b001;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            rr = $urandom_range(0, 99);
            cur = rr < 2 ? bad[$urandom_range(0, 4)] : rr < 60 ? 3'b100 : rr < 80 ? 3'b010 : 3'b001;
         end
         step(($urandom_range(0, 299) == 0) || (mf && $urandom_range(0, 19) == 0),
              cur, $urandom_range(0, 3) == 0);
      end
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
